// File: rtl/ysyx_22050710_dsram_pkg.sv
// +----------------------------------------------------------------------+
// | Module  : ysyx_22050710_dsram_pkg                                     |
// | Brief   : Shared types and limits for the data-SRAM responder.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package ysyx_22050710_dsram_pkg;

    localparam int MAX_LATENCY = 15;
    localparam int CNT_WD      = 4;

    // Control half of a pending entry; the width-dependent payload
    // (wstrb, word index, wdata) travels beside it as a flat vector.
    typedef struct packed {
        logic              wr;
        logic [CNT_WD-1:0] cnt;
    } pend_ctrl_t;

    function automatic logic [CNT_WD-1:0] cnt_load(input int latency);
        return CNT_WD'(latency - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22050710_dsram_if.sv
// +----------------------------------------------------------------------+
// | Module  : ysyx_22050710_dsram_if                                      |
// | Brief   : Split-transaction data-SRAM request/response bundle.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface ysyx_22050710_dsram_if #(
    parameter int ADDR_WD      = 32,
    parameter int SRAM_DATA_WD = 64
);
    logic                      i_req;
    logic                      i_wr;
    logic [SRAM_DATA_WD/8-1:0] i_wstrb;
    logic [ADDR_WD-1:0]        i_addr;
    logic [SRAM_DATA_WD-1:0]   i_wdata;
    logic                      o_addr_ok;
    logic                      o_data_ok;
    logic [SRAM_DATA_WD-1:0]   o_rdata;

    modport master (
        output i_req, i_wr, i_wstrb, i_addr, i_wdata,
        input  o_addr_ok, o_data_ok, o_rdata
    );

    modport slave (
        input  i_req, i_wr, i_wstrb, i_addr, i_wdata,
        output o_addr_ok, o_data_ok, o_rdata
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_22050710_resp_fifo.sv
// +----------------------------------------------------------------------+
// | Module  : ysyx_22050710_resp_fifo                                     |
// | Brief   : In-order pending-request buffer with per-entry countdown.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module ysyx_22050710_resp_fifo
    import ysyx_22050710_dsram_pkg::*;
#(
    parameter  int DEPTH      = 2,
    parameter  int PAYLOAD_WD = 8,
    parameter  int LATENCY    = 2,
    localparam int IDX_WD     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst,
    input  wire logic                  i_push,
    input  wire logic                  i_push_wr,
    input  wire logic [PAYLOAD_WD-1:0] i_push_payload,
    input  wire logic                  i_pop,
    output pend_ctrl_t                 o_head,
    output logic      [PAYLOAD_WD-1:0] o_head_payload,
    output logic                       o_head_valid,
    output logic      [IDX_WD:0]       o_count
);

    localparam int              c_SLOTS    = 1 << IDX_WD;
    localparam logic [CNT_WD-1:0] c_CNT_LOAD = cnt_load(LATENCY);

    logic [IDX_WD:0]         r_wr_ptr;
    logic [IDX_WD:0]         r_rd_ptr;
    logic [c_SLOTS-1:0]      r_valid;
    pend_ctrl_t              r_ctrl    [c_SLOTS];
    logic [PAYLOAD_WD-1:0]   r_payload [c_SLOTS];

    logic [IDX_WD-1:0]       w_wr_idx;
    logic [IDX_WD-1:0]       w_rd_idx;

    assign w_wr_idx = r_wr_ptr[IDX_WD-1:0];
    assign w_rd_idx = r_rd_ptr[IDX_WD-1:0];

    // Every live entry counts down, including those queued behind a head
    // that has not popped yet, so a ready younger entry follows immediately.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= '0;
            for (int i = 0; i < c_SLOTS; i++) begin
                r_ctrl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_SLOTS; i++) begin
                if (r_valid[i] && (r_ctrl[i].cnt != '0)) begin
                    r_ctrl[i].cnt <= r_ctrl[i].cnt - 1'b1;
                end
            end
            if (i_pop) begin
                r_valid[w_rd_idx] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            if (i_push) begin
                r_valid[w_wr_idx] <= 1'b1;
                r_ctrl[w_wr_idx]  <= '{wr: i_push_wr, cnt: c_CNT_LOAD};
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_payload[w_wr_idx] <= i_push_payload;
        end
    end

    assign o_head         = r_ctrl[w_rd_idx];
    assign o_head_payload = r_payload[w_rd_idx];
    assign o_head_valid   = r_valid[w_rd_idx];
    assign o_count        = r_wr_ptr - r_rd_ptr;

endmodule

`default_nettype wire

// File: rtl/ysyx_22050710_dsram_responder.sv
// +----------------------------------------------------------------------+
// | Module  : ysyx_22050710_dsram_responder                               |
// | Brief   : Data-SRAM slave: in-order responses after fixed latency.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module ysyx_22050710_dsram_responder
    import ysyx_22050710_dsram_pkg::*;
#(
    parameter int ADDR_WD      = 32,
    parameter int SRAM_DATA_WD = 64,
    parameter int MEM_DEPTH    = 1024,
    parameter int LATENCY      = 2,
    parameter int FIFO_DEPTH   = 2
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst,
    ysyx_22050710_dsram_if.slave   bus
);

    localparam int c_STRB_WD     = SRAM_DATA_WD / 8;
    localparam int c_OFF_WD      = $clog2(c_STRB_WD);
    localparam int c_IDX_WD      = $clog2(MEM_DEPTH);
    localparam int c_PAYLOAD_WD  = c_STRB_WD + c_IDX_WD + SRAM_DATA_WD;
    localparam int c_FIFO_IDX_WD = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_FIFO_IDX_WD:0] c_FULL = (c_FIFO_IDX_WD + 1)'(FIFO_DEPTH);

    logic [SRAM_DATA_WD-1:0]    r_mem [MEM_DEPTH];

    logic [ADDR_WD-1:0]         w_addr;
    logic                       w_addr_ok;
    logic                       w_data_ok;
    logic                       w_push;
    logic [c_PAYLOAD_WD-1:0]    w_push_payload;
    pend_ctrl_t                 w_head;
    logic [c_PAYLOAD_WD-1:0]    w_head_payload;
    logic                       w_head_valid;
    logic [c_FIFO_IDX_WD:0]     w_count;
    logic [c_STRB_WD-1:0]       w_head_wstrb;
    logic [c_IDX_WD-1:0]        w_head_idx;
    logic [SRAM_DATA_WD-1:0]    w_head_wdata;
    logic [SRAM_DATA_WD-1:0]    w_cur_word;
    logic [SRAM_DATA_WD-1:0]    w_merged;

    // No credit for a same-cycle pop keeps data_ok off the addr_ok path.
    assign w_addr    = bus.i_addr;
    assign w_addr_ok = (w_count < c_FULL) && i_rst;
    assign w_push    = bus.i_req && w_addr_ok;
    assign w_data_ok = w_head_valid && (w_head.cnt == '0);

    // Byte offset and bits above the array are dropped: addresses alias.
    assign w_push_payload = {bus.i_wstrb, w_addr[c_OFF_WD +: c_IDX_WD], bus.i_wdata};

    ysyx_22050710_resp_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .PAYLOAD_WD (c_PAYLOAD_WD),
        .LATENCY    (LATENCY)
    ) u_resp_fifo (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_push         (w_push),
        .i_push_wr      (bus.i_wr),
        .i_push_payload (w_push_payload),
        .i_pop          (w_data_ok),
        .o_head         (w_head),
        .o_head_payload (w_head_payload),
        .o_head_valid   (w_head_valid),
        .o_count        (w_count)
    );

    assign {w_head_wstrb, w_head_idx, w_head_wdata} = w_head_payload;
    assign w_cur_word = r_mem[w_head_idx];

    for (genvar g = 0; g < c_STRB_WD; g++) begin : g_lane
        assign w_merged[8*g +: 8] = w_head_wstrb[g] ? w_head_wdata[8*g +: 8]
                                                    : w_cur_word[8*g +: 8];
    end

    // Writes land at response time, keeping memory order equal to request order.
    always_ff @(posedge i_clk) begin
        if (w_data_ok && w_head.wr) begin
            r_mem[w_head_idx] <= w_merged;
        end
    end

    assign bus.o_addr_ok = w_addr_ok;
    assign bus.o_data_ok = w_data_ok;
    assign bus.o_rdata   = (w_data_ok && !w_head.wr) ? w_cur_word : '0;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050710_dsram_responder.sv
// +----------------------------------------------------------------------+
// | Module  : tb_ysyx_22050710_dsram_responder                            |
// | Brief   : Self-checking bench against a queue-based response model.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ysyx_22050710_dsram_responder;

    localparam int L = 2;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_22050710_dsram_if #(.ADDR_WD(32), .SRAM_DATA_WD(64)) bus  ();
    ysyx_22050710_dsram_if #(.ADDR_WD(32), .SRAM_DATA_WD(64)) bus1 ();
    ysyx_22050710_dsram_if #(.ADDR_WD(32), .SRAM_DATA_WD(64)) bus3 ();

    ysyx_22050710_dsram_responder #(.LATENCY(L), .FIFO_DEPTH(D)) u_dut (
        .i_clk(clk), .i_rst(rst_n), .bus(bus));
    ysyx_22050710_dsram_responder #(.LATENCY(1), .FIFO_DEPTH(2)) u_dut1 (
        .i_clk(clk), .i_rst(rst_n), .bus(bus1));
    ysyx_22050710_dsram_responder #(.LATENCY(3), .FIFO_DEPTH(2)) u_dut3 (
        .i_clk(clk), .i_rst(rst_n), .bus(bus3));

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference model: pending requests with the cycle they become due.
    typedef struct {
        bit        wr;
        bit [7:0]  strb;
        int        idx;
        bit [63:0] wdata;
        int        due;
    } req_t;

    req_t        mq[$];
    logic [63:0] mmem [1024];
    int          cyc = 0;
    bit          last_acc;
    logic [63:0] last_rdata;

    task automatic drive(input bit req, input bit wr, input bit [7:0] strb,
                         input bit [31:0] addr, input bit [63:0] wdata);
        bus.i_req   = req;
        bus.i_wr    = wr;
        bus.i_wstrb = strb;
        bus.i_addr  = addr;
        bus.i_wdata = wdata;
    endtask

    task automatic step_main(input string tag);
        bit          exp_aok;
        bit          exp_dok;
        logic [63:0] exp_rd;
        req_t        r;
        @(negedge clk);
        if (!rst_n) mq.delete();
        exp_aok = rst_n && (mq.size() < D);
        exp_dok = (mq.size() > 0) && (cyc >= mq[0].due);
        exp_rd  = 64'h0;
        if (exp_dok && !mq[0].wr) exp_rd = mmem[mq[0].idx];
        check({tag, ".addr_ok"}, 64'(bus.o_addr_ok), 64'(exp_aok));
        check({tag, ".data_ok"}, 64'(bus.o_data_ok), 64'(exp_dok));
        check({tag, ".rdata"},   bus.o_rdata, exp_rd);
        if (bus.o_data_ok) last_rdata = bus.o_rdata;
        last_acc = bus.i_req && exp_aok;
        @(posedge clk);
        #1;
        if (exp_dok) begin
            r = mq.pop_front();
            if (r.wr)
                for (int b = 0; b < 8; b++)
                    if (r.strb[b]) mmem[r.idx][8*b +: 8] = r.wdata[8*b +: 8];
        end
        if (last_acc) begin
            r.wr = bus.i_wr; r.strb = bus.i_wstrb; r.wdata = bus.i_wdata;
            r.idx = int'((bus.i_addr >> 3) % 1024);
            r.due = cyc + L;
            mq.push_back(r);
        end
        cyc++;
    endtask

    task automatic issue(input string tag, input bit wr, input bit [7:0] strb,
                         input bit [31:0] addr, input bit [63:0] wdata);
        int tries = 0;
        drive(1'b1, wr, strb, addr, wdata);
        do begin
            step_main(tag);
            tries++;
        end while (!last_acc && tries < 20);
        if (!last_acc) check({tag, ".accept_timeout"}, 64'd0, 64'd1);
        drive(1'b0, 1'b0, 8'h0, 32'h0, 64'h0);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step_main(tag);
    endtask

    logic [63:0] m1 [16];
    logic [63:0] m3 [16];
    int          dq_due[$];
    int          dq_idx[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          i1, i3, nexti;
        bit          a1, a3, e_aok, e_dok;
        logic [63:0] e_rd;
        bit [31:0]   addr;

        drive(1'b0, 1'b0, 8'h0, 32'h0, 64'h0);
        {bus1.i_req, bus1.i_wr, bus1.i_wstrb, bus1.i_addr, bus1.i_wdata} = '0;
        {bus3.i_req, bus3.i_wr, bus3.i_wstrb, bus3.i_addr, bus3.i_wdata} = '0;
        for (int i = 0; i < 16; i++) begin
            m1[i] = {$urandom, $urandom};
            m3[i] = {$urandom, $urandom};
        end

        #1;
        idle("reset", 3);
        rst_n = 1'b1;
        idle("post_reset", 1);

        // Preload words 0..15 of the main array through the bus.
        for (int i = 0; i < 16; i++)
            issue("preload", 1'b1, 8'hFF, 32'(i * 8),
                  (i == 5) ? 64'h1122334455667788 : {$urandom, $urandom});
        idle("drain", 4);

        last_rdata = 'x;
        issue("rd28", 1'b0, 8'h00, 32'h28, 64'h0);
        idle("rd28_wait", 3);
        check("rd28.value", last_rdata, 64'h1122334455667788);

        issue("wr28", 1'b1, 8'h0F, 32'h28, 64'hAAAAAAAA_BBBBBBBB);
        issue("rd2c", 1'b0, 8'h00, 32'h2C, 64'h0);
        idle("wr_rd_wait", 4);
        check("rd2c.merged", last_rdata, 64'h11223344_BBBBBBBB);

        last_rdata = 'x;
        issue("rd2028", 1'b0, 8'h00, 32'h2028, 64'h0);
        idle("wrap_wait", 3);
        check("wrap.value", last_rdata, 64'h11223344_BBBBBBBB);

        // Reset while a write and a read are outstanding.
        issue("rst_wr", 1'b1, 8'hFF, 32'h28, 64'hDEADBEEF_CAFEF00D);
        issue("rst_rd", 1'b0, 8'h00, 32'h30, 64'h0);
        rst_n = 1'b0;
        idle("mid_reset", 2);
        rst_n = 1'b1;
        idle("after_reset", 3);
        last_rdata = 'x;
        issue("rd28_after", 1'b0, 8'h00, 32'h28, 64'h0);
        idle("rd28_after_wait", 3);
        check("reset.no_write", last_rdata, 64'h11223344_BBBBBBBB);

        // Randomized traffic; a rejected request holds its payload.
        drive(1'b0, 1'b0, 8'h0, 32'h0, 64'h0);
        last_acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!bus.i_req || last_acc) begin
                addr = {16'h0, 3'($urandom_range(0, 7)), 6'h0, 4'($urandom_range(0, 15)),
                        3'($urandom_range(0, 7))};
                drive(($urandom % 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom),
                      addr, {$urandom, $urandom});
            end
            step_main("rand");
        end
        drive(1'b0, 1'b0, 8'h0, 32'h0, 64'h0);
        idle("rand_drain", 6);

        // Preload the latency-1 and latency-3 instances.
        i1 = 0; i3 = 0;
        for (int c = 0; c < 100 && (i1 < 16 || i3 < 16); c++) begin
            bus1.i_req = (i1 < 16); bus1.i_wr = 1'b1; bus1.i_wstrb = 8'hFF;
            bus1.i_addr = 32'(i1 * 8); bus1.i_wdata = m1[i1 % 16];
            bus3.i_req = (i3 < 16); bus3.i_wr = 1'b1; bus3.i_wstrb = 8'hFF;
            bus3.i_addr = 32'(i3 * 8); bus3.i_wdata = m3[i3 % 16];
            @(negedge clk);
            a1 = bus1.i_req && bus1.o_addr_ok;
            a3 = bus3.i_req && bus3.o_addr_ok;
            @(posedge clk); #1;
            if (a1) i1++;
            if (a3) i3++;
        end
        bus1.i_req = 1'b0; bus3.i_req = 1'b0;
        check("aux_preload.done", 64'(i1 + i3), 64'd32);
        repeat (6) @(posedge clk);
        #1;

        // Latency 1: eight back-to-back reads give eight back-to-back responses.
        for (int c = 0; c < 11; c++) begin
            bus1.i_req = (c < 8); bus1.i_wr = 1'b0; bus1.i_wstrb = 8'h0;
            bus1.i_addr = 32'((c % 8) * 8); bus1.i_wdata = 64'h0;
            e_dok = (c >= 1) && (c <= 8);
            e_rd  = e_dok ? m1[c - 1] : 64'h0;
            @(negedge clk);
            if (c < 8) check("l1.addr_ok", 64'(bus1.o_addr_ok), 64'd1);
            check("l1.data_ok", 64'(bus1.o_data_ok), 64'(e_dok));
            check("l1.rdata", bus1.o_rdata, e_rd);
            @(posedge clk); #1;
        end
        bus1.i_req = 1'b0;

        // Latency 3, depth 2, request held high: at most two outstanding.
        nexti = 0;
        for (int c = 0; c < 16; c++) begin
            bus3.i_req = 1'b1; bus3.i_wr = 1'b0; bus3.i_wstrb = 8'h0;
            bus3.i_addr = 32'(nexti * 8); bus3.i_wdata = 64'h0;
            e_aok = dq_due.size() < 2;
            e_dok = (dq_due.size() > 0) && (c >= dq_due[0]);
            e_rd  = 64'h0;
            if (e_dok) e_rd = m3[dq_idx[0]];
            @(negedge clk);
            check("l3.addr_ok", 64'(bus3.o_addr_ok), 64'(e_aok));
            check("l3.data_ok", 64'(bus3.o_data_ok), 64'(e_dok));
            check("l3.rdata", bus3.o_rdata, e_rd);
            @(posedge clk); #1;
            if (e_dok) begin
                void'(dq_due.pop_front());
                void'(dq_idx.pop_front());
            end
            if (e_aok) begin
                dq_due.push_back(c + 3);
                dq_idx.push_back(nexti);
                nexti++;
            end
        end
        bus3.i_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
